// File: rtl/aes_128_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 inverse cipher.
package aes_128_pkg;

    localparam int unsigned BLOCK_W        = 128;
    localparam int unsigned NUM_ROUND_KEYS = 11;
    localparam int unsigned RND_W          = 4;

    typedef enum logic {IDLE, BUSY} fsm_t;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // Row r rotates right by r; byte index = col*4 + row, byte 0 at bit 127.
    function automatic logic [BLOCK_W-1:0] inv_shiftrows(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-8*(c*4+row) -: 8] = s[127-8*(((c-row+4)%4)*4+row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [BLOCK_W-1:0] inv_sub_bytes(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_128_inv_mixcol.sv
// Combinational InvMixColumns over a full 128-bit state, one slice per column.
module aes_128_inv_mixcol
    import aes_128_pkg::*;
(
    input  logic [BLOCK_W-1:0] xored,
    output logic [BLOCK_W-1:0] mixed_c
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = xored[127-32*c -: 8];
        assign a1 = xored[119-32*c -: 8];
        assign a2 = xored[111-32*c -: 8];
        assign a3 = xored[103-32*c -: 8];

        assign mixed_c[127-32*c -: 8] = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
        assign mixed_c[119-32*c -: 8] = gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
        assign mixed_c[111-32*c -: 8] = gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3);
        assign mixed_c[103-32*c -: 8] = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3);
    end

endmodule

// File: rtl/aes_128_inv_top.sv
// Iterative AES-128 inverse cipher: one round per clock, one block in flight,
// round keys loaded in encryption order and consumed from rk10 down to rk0.
module aes_128_inv_top
    import aes_128_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS      = 10,
    parameter bit          KEY_WR_BUSY_IRQ = 1'b1
) (
    input  logic               clk,
    input  logic               kill,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic               in_en,
    input  logic               en_wr,
    input  logic [BLOCK_W-1:0] key_round_wr,
    output logic               key_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               out_en,
    output logic               idle,
    output logic               in_en_collision_irq_pulse
);

    localparam logic [RND_W-1:0] LAST_RK = RND_W'(NUM_ROUNDS);

    fsm_t               fsm;
    logic [BLOCK_W-1:0] state;
    logic [RND_W-1:0]   rnd;
    logic [RND_W-1:0]   wr_ptr;
    logic [BLOCK_W-1:0] rk [NUM_ROUND_KEYS];

    logic               accept;
    logic               in_drop;
    logic               key_wr;
    logic               key_drop;
    logic [BLOCK_W-1:0] round_xor;
    logic [BLOCK_W-1:0] mixed;

    assign idle     = (fsm == IDLE) && key_ready;
    assign accept   = in_en && idle;
    assign in_drop  = in_en && !idle;
    // A start request in the same cycle takes priority over a key write.
    assign key_wr   = en_wr && (fsm == IDLE) && !accept;
    assign key_drop = en_wr && !key_wr;

    // rnd is 0 on the final round, so this also yields the plaintext.
    assign round_xor = inv_sub_bytes(inv_shiftrows(state)) ^ rk[rnd];

    aes_128_inv_mixcol u_mixcol (
        .xored   (round_xor),
        .mixed_c (mixed)
    );

    // Key storage is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (key_wr) begin
            rk[wr_ptr] <= key_round_wr;
        end
    end

    always_ff @(posedge clk or posedge kill) begin
        if (kill) begin
            fsm                       <= IDLE;
            state                     <= '0;
            rnd                       <= '0;
            wr_ptr                    <= '0;
            key_ready                 <= 1'b0;
            out_data                  <= '0;
            out_en                    <= 1'b0;
            in_en_collision_irq_pulse <= 1'b0;
        end else begin
            out_en                    <= 1'b0;
            in_en_collision_irq_pulse <= in_drop || (KEY_WR_BUSY_IRQ && key_drop);

            if (key_wr) begin
                if (wr_ptr == LAST_RK) begin
                    wr_ptr    <= '0;
                    key_ready <= 1'b1;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (wr_ptr == '0) begin
                        key_ready <= 1'b0;
                    end
                end
            end

            case (fsm)
                IDLE: begin
                    if (accept) begin
                        state <= in_data ^ rk[LAST_RK];
                        rnd   <= LAST_RK - 1'b1;
                        fsm   <= BUSY;
                    end
                end
                BUSY: begin
                    if (rnd != '0) begin
                        state <= mixed;
                        rnd   <= rnd - 1'b1;
                    end else begin
                        out_data <= round_xor;
                        out_en   <= 1'b1;
                        fsm      <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule
